alu_regfile_datapath: RTL and testbench
=======================================

// Module: alu_regfile_datapath
// PURPOSE
//  Register-file + ALU datapath that consumes the per-cycle control word
//  (regControl/regACont/regBCont/AluOp) emitted by the control sequencer FSMs.
//  Holds 16 x 16-bit registers and a 5-bit flag register. Each cycle it reads
//  two operands, computes one ALU result and writes it back on the clock edge.
// PARAMETERS
//  WIDTH   16  data/register width (only 16 supported)
//  NREGS   16  register count; equals regControl width
//  SEL_W   4   register-select width, log2(NREGS)
// PORTS
//  clock       in   1      single clock, all state on posedge
//  Reset       in   1      asynchronous, active-low reset
//  regControl  in   16     one-hot-or-multi write enables; bit i loads Ri
//  regACont    in   4      operand A register select
//  regBCont    in   4      operand B register select
//  AluOp       in   8      operation code (table below)
//  imm         in   16     immediate operand for LOADI
//  result_q    out  16     registered ALU result of last executed op
//  flags_q     out  5      {C,L,F,Z,N}, registered
//  dbg_sel     in   4      debug read select
//  dbg_data    out  16     combinational read of R[dbg_sel]
// BEHAVIOUR
//  - Reset low (async): R0..R15 = 0, result_q = 0, flags_q = 0. No writes while low.
//  - A = R[regACont], B = R[regBCont], read combinationally from pre-edge state.
//    A write and a read of the same register in one cycle: the read returns the old value.
//  - Posedge: every Ri with regControl[i]=1 loads res; several bits may be set
//    (broadcast write). result_q loads res when regControl!=0 or op=CMP.
//  - regControl=0 and op!=CMP: no state changes at all; select/op inputs may be X.
//  - AluOp: 00 PASS(B)  01 ADD A+B  02 ADDC A+B+C  05 AND  06 OR  08 SUB A-B
//    09 DEC A-1  0B CMP (A-B, flags only, never writes Ri even if regControl!=0)
//    0F XOR  11 LSH A<<B[3:0]  12 RSH logical A>>B[3:0]  20 LOADI res=imm.
//    Any other code: res=0, no register/flag/result_q update.
//  - Arithmetic is modulo 2^16. Shift amount is B[3:0]; B[15:4] ignored.
//  - Flags update only on an executing cycle (same condition as result_q):
//    ADD/ADDC: C=carry-out, F=signed overflow; L,N cleared.
//    SUB/DEC/CMP: C=borrow (A<B unsigned), L=A<B unsigned, N=A<B signed,
//    F=signed overflow. DEC uses B=1.
//    Z=(res==0) for every executing op (CMP: A==B).
//    PASS/logic/shift/LOADI: Z updated; C,L,F,N held.
//  - Latency: one edge from control word to visible register/flag/result_q.
//  - Reset asserted mid-sequence clears all state immediately; the first
//    posedge after release executes the control word then present.
// STRUCTURE
//  - datapath_pkg: AluOp localparams, flag bit indices (C=4,L=3,F=2,Z=1,N=0),
//    WIDTH/SEL_W constants, shared with the sequencer FSMs.
//  - Sub-module alu16: purely combinational; (A,B,imm,Cin,AluOp) ->
//    (res, flag vector, flag update mask, valid). Top level holds the
//    register array, flag register, result_q and write decode.
// TESTING
//  1 Reset, LOADI imm=0001 regControl=0003 -> R0=R1=1, Z=0, result_q=0001.
//  2 ADD A=R1,B=R0,ctl=0004 -> R2=2; LSH A=R2,B=R2,ctl=0008 -> R3=0008;
//    DEC A=R3,ctl=0010 -> R4=0007.
//  3 SUB A=R4(7),B=R3(8),ctl=0040 -> R6=FFFF, C=1,L=1,N=1,Z=0,F=0;
//    XOR A=R4,B=R2,ctl=0080 -> R7=0005.
//  4 R5=7FFF,R6=0001: ADD ctl=0100 -> R8=8000,F=1,C=0; CMP R4,R4 with
//    ctl=FFFF -> no register changes, Z=1.
//  5 Write R2 while reading R2 as A in the same cycle -> res uses old R2;
//    ctl=0000 with X selects and op 01 -> no state change; op 7E -> no update.
//  6 Pulse Reset low between edges mid-sequence -> all regs, flags, result_q
//    read 0 before next edge; sequence restarts cleanly.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | datapath_pkg : shared ALU opcodes, flag indices and datapath widths     |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
package datapath_pkg;

  localparam int c_WIDTH  = 16;
  localparam int c_SEL_W  = 4;
  localparam int c_NREGS  = 16;
  localparam int c_FLAG_W = 5;

  typedef logic [c_FLAG_W-1:0] flags_t;

  localparam logic [7:0] c_OP_PASS  = 8'h00;
  localparam logic [7:0] c_OP_ADD   = 8'h01;
  localparam logic [7:0] c_OP_ADDC  = 8'h02;
  localparam logic [7:0] c_OP_AND   = 8'h05;
  localparam logic [7:0] c_OP_OR    = 8'h06;
  localparam logic [7:0] c_OP_SUB   = 8'h08;
  localparam logic [7:0] c_OP_DEC   = 8'h09;
  localparam logic [7:0] c_OP_CMP   = 8'h0B;
  localparam logic [7:0] c_OP_XOR   = 8'h0F;
  localparam logic [7:0] c_OP_LSH   = 8'h11;
  localparam logic [7:0] c_OP_RSH   = 8'h12;
  localparam logic [7:0] c_OP_LOADI = 8'h20;

  localparam int c_FLAG_C = 4;
  localparam int c_FLAG_L = 3;
  localparam int c_FLAG_F = 2;
  localparam int c_FLAG_Z = 1;
  localparam int c_FLAG_N = 0;

endpackage
`default_nettype wire

// File: rtl/alu16.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu16 : combinational 16-bit ALU returning result, flags and flag mask  |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module alu16
  import datapath_pkg::*;
(
  input  logic [c_WIDTH-1:0] i_a,
  input  logic [c_WIDTH-1:0] i_b,
  input  logic [c_WIDTH-1:0] i_imm,
  input  logic               i_cin,
  input  logic [7:0]         i_op,
  output logic [c_WIDTH-1:0] o_res,
  output flags_t             o_flags,
  output flags_t             o_mask,
  output logic               o_valid
);

  logic [c_WIDTH:0]   w_sum;
  logic [c_WIDTH:0]   w_diff;
  logic [c_WIDTH-1:0] w_sub_b;
  logic               w_cin;

  // DEC shares the subtractor with B forced to one
  assign w_sub_b = (i_op == c_OP_DEC) ? c_WIDTH'(1) : i_b;
  assign w_cin   = (i_op == c_OP_ADDC) ? i_cin : 1'b0;
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{c_WIDTH{1'b0}}, w_cin};
  assign w_diff  = {1'b0, i_a} - {1'b0, w_sub_b};

  always_comb begin
    o_res   = '0;
    o_flags = '0;
    o_mask  = '0;
    o_valid = 1'b1;
    case (i_op)
      c_OP_PASS:  begin o_res = i_b;               o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_AND:   begin o_res = i_a & i_b;         o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_OR:    begin o_res = i_a | i_b;         o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_XOR:   begin o_res = i_a ^ i_b;         o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_LSH:   begin o_res = i_a << i_b[3:0];   o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_RSH:   begin o_res = i_a >> i_b[3:0];   o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_LOADI: begin o_res = i_imm;             o_mask[c_FLAG_Z] = 1'b1; end
      c_OP_ADD, c_OP_ADDC: begin
        o_res            = w_sum[c_WIDTH-1:0];
        o_mask           = '1;
        o_flags[c_FLAG_C] = w_sum[c_WIDTH];
        o_flags[c_FLAG_F] = (i_a[c_WIDTH-1] == i_b[c_WIDTH-1]) &&
                            (w_sum[c_WIDTH-1] != i_a[c_WIDTH-1]);
      end
      c_OP_SUB, c_OP_DEC, c_OP_CMP: begin
        o_res             = w_diff[c_WIDTH-1:0];
        o_mask            = '1;
        o_flags[c_FLAG_C] = w_diff[c_WIDTH];
        o_flags[c_FLAG_L] = w_diff[c_WIDTH];
        o_flags[c_FLAG_N] = $signed(i_a) < $signed(w_sub_b);
        o_flags[c_FLAG_F] = (i_a[c_WIDTH-1] != w_sub_b[c_WIDTH-1]) &&
                            (w_diff[c_WIDTH-1] != i_a[c_WIDTH-1]);
      end
      default: o_valid = 1'b0;
    endcase
    o_flags[c_FLAG_Z] = (o_res == '0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_regfile_datapath.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_regfile_datapath : 16x16 register file, ALU, flags and result reg   |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module alu_regfile_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int SEL_W = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic [NREGS-1:0] regControl,
  input  logic [SEL_W-1:0] regACont,
  input  logic [SEL_W-1:0] regBCont,
  input  logic [7:0]       AluOp,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] result_q,
  output logic [4:0]       flags_q,
  input  logic [SEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_result;
  flags_t           r_flags;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  flags_t           w_flags;
  flags_t           w_mask;
  logic             w_valid;
  logic             w_is_cmp;
  logic             w_exec;
  logic [NREGS-1:0] w_wr_en;

  assign w_a      = r_regs[regACont];
  assign w_b      = r_regs[regBCont];
  assign dbg_data = r_regs[dbg_sel];

  alu16 u_alu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_imm   (imm),
    .i_cin   (r_flags[c_FLAG_C]),
    .i_op    (AluOp),
    .o_res   (w_res),
    .o_flags (w_flags),
    .o_mask  (w_mask),
    .o_valid (w_valid)
  );

  // CMP executes with no write enables but never writes the register file
  assign w_is_cmp = (AluOp == c_OP_CMP);
  assign w_exec   = w_valid && ((|regControl) || w_is_cmp);
  assign w_wr_en  = (w_valid && !w_is_cmp) ? regControl : '0;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_en[i]) r_regs[i] <= w_res;
      end
      if (w_exec) begin
        r_result <= w_res;
        r_flags  <= (r_flags & ~w_mask) | (w_flags & w_mask);
      end
    end
  end

  assign result_q = r_result;
  assign flags_q  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile_datapath.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_alu_regfile_datapath : directed self-checking bench for the datapath |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_alu_regfile_datapath;

  logic        clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] regControl = '0;
  logic [3:0]  regACont = '0;
  logic [3:0]  regBCont = '0;
  logic [7:0]  AluOp = '0;
  logic [15:0] imm = '0;
  logic [15:0] result_q;
  logic [4:0]  flags_q;
  logic [3:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_regfile_datapath #(.WIDTH(16), .NREGS(16), .SEL_W(4)) dut (
    .clock      (clock),
    .Reset      (Reset),
    .regControl (regControl),
    .regACont   (regACont),
    .regBCont   (regBCont),
    .AluOp      (AluOp),
    .imm        (imm),
    .result_q   (result_q),
    .flags_q    (flags_q),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkreg(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic chkrf(input string tag, input logic [15:0] res, input logic [4:0] flg);
    chk({tag, "_res"}, result_q, res);
    chk({tag, "_flags"}, {11'd0, flags_q}, {11'd0, flg});
  endtask

  task automatic step(input logic [15:0] ctl, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] op, input logic [15:0] im);
    @(negedge clock);
    regControl = ctl;
    regACont   = a;
    regBCont   = b;
    AluOp      = op;
    imm        = im;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // flags are {C,L,F,Z,N}
  initial begin
    #12;
    chkrf("reset", 16'h0000, 5'b00000);
    chkreg("reset_R0", 4'd0, 16'h0000);
    chkreg("reset_R15", 4'd15, 16'h0000);
    @(negedge clock);
    Reset = 1'b1;

    step(16'h0003, 4'd0, 4'd0, 8'h20, 16'h0001);
    chkrf("loadi", 16'h0001, 5'b00000);
    chkreg("loadi_R0", 4'd0, 16'h0001);
    chkreg("loadi_R1", 4'd1, 16'h0001);
    chkreg("loadi_R2", 4'd2, 16'h0000);

    step(16'h0004, 4'd1, 4'd0, 8'h01, 16'h0000);
    chkreg("add_R2", 4'd2, 16'h0002);
    step(16'h0008, 4'd2, 4'd2, 8'h11, 16'h0000);
    chkreg("lsh_R3", 4'd3, 16'h0008);
    step(16'h0010, 4'd3, 4'd0, 8'h09, 16'h0000);
    chkreg("dec_R4", 4'd4, 16'h0007);
    chkrf("dec", 16'h0007, 5'b00000);

    step(16'h0040, 4'd4, 4'd3, 8'h08, 16'h0000);
    chkreg("sub_R6", 4'd6, 16'hFFFF);
    chkrf("sub", 16'hFFFF, 5'b11001);
    step(16'h0080, 4'd4, 4'd2, 8'h0F, 16'h0000);
    chkreg("xor_R7", 4'd7, 16'h0005);
    chkrf("xor_hold", 16'h0005, 5'b11001);

    step(16'h0020, 4'd0, 4'd0, 8'h20, 16'h7FFF);
    step(16'h0040, 4'd0, 4'd0, 8'h20, 16'h0001);
    step(16'h0100, 4'd5, 4'd6, 8'h01, 16'h0000);
    chkreg("ovf_R8", 4'd8, 16'h8000);
    chkrf("ovf", 16'h8000, 5'b00100);

    step(16'h0200, 4'd0, 4'd0, 8'h20, 16'hFFFF);
    step(16'h0400, 4'd9, 4'd1, 8'h01, 16'h0000);
    chkreg("carry_R10", 4'd10, 16'h0000);
    chkrf("carry", 16'h0000, 5'b10010);
    step(16'h0800, 4'd1, 4'd1, 8'h02, 16'h0000);
    chkreg("addc_R11", 4'd11, 16'h0003);
    chkrf("addc", 16'h0003, 5'b00000);

    step(16'hFFFF, 4'd4, 4'd4, 8'h0B, 16'h1234);
    chkrf("cmp_eq", 16'h0000, 5'b00010);
    chkreg("cmp_R0", 4'd0, 16'h0001);
    chkreg("cmp_R4", 4'd4, 16'h0007);
    chkreg("cmp_R8", 4'd8, 16'h8000);

    step(16'h0004, 4'd2, 4'd2, 8'h01, 16'h0000);
    chkreg("rw_R2", 4'd2, 16'h0004);
    chkrf("rw", 16'h0004, 5'b00000);

    @(negedge clock);
    regControl = 16'h0000;
    regACont   = 4'bxxxx;
    regBCont   = 4'bxxxx;
    AluOp      = 8'h01;
    @(posedge clock);
    #1;
    chkrf("idle", 16'h0004, 5'b00000);
    chkreg("idle_R2", 4'd2, 16'h0004);

    step(16'hFFFF, 4'd1, 4'd2, 8'h7E, 16'h5555);
    chkrf("badop", 16'h0004, 5'b00000);
    chkreg("badop_R0", 4'd0, 16'h0001);
    chkreg("badop_R15", 4'd15, 16'h0000);

    step(16'h1000, 4'd8, 4'd3, 8'h12, 16'h0000);
    chkreg("rsh_R12", 4'd12, 16'h0080);
    step(16'h2000, 4'd12, 4'd7, 8'h05, 16'h0000);
    chkreg("and_R13", 4'd13, 16'h0000);
    chkrf("and", 16'h0000, 5'b00010);
    step(16'h4000, 4'd1, 4'd9, 8'h11, 16'h0000);
    chkreg("lsh15_R14", 4'd14, 16'h8000);
    step(16'h0002, 4'd12, 4'd7, 8'h06, 16'h0000);
    chkreg("or_R1", 4'd1, 16'h0085);
    step(16'h8000, 4'd0, 4'd7, 8'h00, 16'h0000);
    chkreg("pass_R15", 4'd15, 16'h0005);
    step(16'h0000, 4'd4, 4'd3, 8'h0B, 16'h0000);
    chkrf("cmp_lt", 16'hFFFF, 5'b11001);

    Reset = 1'b0;
    #1;
    chkrf("midrst", 16'h0000, 5'b00000);
    chkreg("midrst_R0", 4'd0, 16'h0000);
    chkreg("midrst_R8", 4'd8, 16'h0000);
    Reset = 1'b1;
    step(16'h0003, 4'd0, 4'd0, 8'h20, 16'h0001);
    chkrf("restart", 16'h0001, 5'b00000);
    chkreg("restart_R1", 4'd1, 16'h0001);
    chkreg("restart_R15", 4'd15, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
